// File: rtl/fetch_responder.sv
// rtl/fetch_responder.sv - single-line instruction buffer between fetch and instruction memory
//
// Purpose:
//   Answers fetch's PC combinationally from a one-line instruction buffer.
//   A miss refills the whole line, word 0 upward, over a word-wide
//   request/acknowledge read port; stall_out is high until the line is valid.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   pc_in          in   fetch PC; bits [1:0] are ignored
//   set_pc_in      in   fetch redirect, high in the cycle fetch loads a new PC
//   instr_out      out  instruction for pc_in (NOP_INSTR when stalled)
//   stall_out      out  high when instr_out is not valid
//   mem_req        out  memory read request, held until mem_ack
//   mem_addr       out  word-aligned read address, held until mem_ack
//   mem_ack        in   request accepted and mem_rdata valid this cycle
//   mem_rdata      in   read data
//   hit_count_out  out  (FETCH_RESPONDER_PERF_EN only) saturating hit counter
//   miss_count_out out  (FETCH_RESPONDER_PERF_EN only) saturating miss counter
//
// Build option:
//   FETCH_RESPONDER_PERF_EN adds the hit/miss performance counters.

module fetch_responder #(
  parameter int unsigned LINE_WORDS_LOG2 = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        set_pc_in,
  output logic [31:0] instr_out,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef FETCH_RESPONDER_PERF_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);

  localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int unsigned TAG_W      = 32 - LINE_WORDS_LOG2 - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

  state_t                           state_q, state_d;
  logic                             line_valid_q, line_valid_d;
  logic [LINE_WORDS_LOG2-1:0]       beat_q, beat_d;
  logic [TAG_W-1:0]                 line_tag_q, line_tag_d;
  logic [LINE_WORDS-1:0][31:0]      line_q, line_d;

  logic [TAG_W-1:0]                 pc_tag;
  logic [LINE_WORDS_LOG2-1:0]       pc_word;
  logic                             hit;
  logic                             last_beat;
  logic                             unused_pc_bits;

  assign pc_tag         = pc_in[31:LINE_WORDS_LOG2+2];
  assign pc_word        = pc_in[LINE_WORDS_LOG2+1:2];
  assign unused_pc_bits = &{1'b0, pc_in[1:0]};

  // Lookups only resolve in IDLE; during a fill the buffer is being rewritten.
  assign hit       = (state_q == ST_IDLE) && line_valid_q && (pc_tag == line_tag_q);
  assign last_beat = (beat_q == {LINE_WORDS_LOG2{1'b1}});

  // Fetch-facing outputs.
  assign instr_out = hit ? line_q[pc_word] : NOP_INSTR;
  assign stall_out = !hit;

  // The request is a pure function of the state register, so it stays stable
  // until acknowledged and falls the instant reset forces the state to IDLE.
  assign mem_req  = (state_q != ST_IDLE);
  assign mem_addr = mem_req ? {line_tag_q, beat_q, 2'b00} : 32'h0;

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    beat_d       = beat_q;
    line_tag_d   = line_tag_q;
    line_d       = line_q;

    case (state_q)
      ST_IDLE: begin
        // A redirect needs no handling here: the new PC is simply looked up.
        if (!hit) begin
          state_d      = ST_FILL;
          line_tag_d   = pc_tag;
          beat_d       = '0;
          line_valid_d = 1'b0;
        end
      end

      ST_FILL: begin
        if (mem_ack) begin
          if (last_beat) begin
            // Completing the line wins over a simultaneous redirect.
            line_d[beat_q] = mem_rdata;
            line_valid_d   = 1'b1;
            state_d        = ST_IDLE;
          end else if (set_pc_in) begin
            // Redirected mid-line: the partial line is useless, drop it.
            state_d = ST_IDLE;
          end else begin
            line_d[beat_q] = mem_rdata;
            beat_d         = beat_q + LINE_WORDS_LOG2'(1);
          end
        end else if (set_pc_in) begin
          // The request is already on the bus and cannot be withdrawn.
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        line_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      beat_q       <= '0;
      line_tag_q   <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      beat_q       <= beat_d;
      line_tag_q   <= line_tag_d;
      line_q       <= line_d;
    end
  end

`ifdef FETCH_RESPONDER_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        miss_start;

  assign miss_start = (state_q == ST_IDLE) && !hit;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && !set_pc_in && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_out  = hit_count_q;
  assign miss_count_out = miss_count_q;
`endif

endmodule

// File: tb/tb_fetch_responder.sv
// tb/tb_fetch_responder.sv - self-checking bench for fetch_responder

module tb_fetch_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        set_pc_in = 1'b0;
  logic [31:0] instr_out;
  logic        stall_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef FETCH_RESPONDER_PERF_EN
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;
`endif

  int checks = 0;
  int errors = 0;

  fetch_responder dut (
    .clock     (clock),
    .reset     (reset),
    .pc_in     (pc_in),
    .set_pc_in (set_pc_in),
    .instr_out (instr_out),
    .stall_out (stall_out),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef FETCH_RESPONDER_PERF_EN
    ,
    .hit_count_out  (hit_count_out),
    .miss_count_out (miss_count_out)
`endif
  );

  always #5 clock = ~clock;

  // Memory contents: a bijective scramble of the address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C96_A55A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the line is a list of words received so far; it becomes
  // usable once all four words of one uninterrupted fill have arrived.
  logic        m_valid;
  logic [27:0] m_tag;
  logic [31:0] m_line [4];
  logic [31:0] m_words [$];
  bit          m_fill;
  bit          m_drain;
  logic [27:0] m_fill_tag;
  logic [31:0] m_drain_addr;
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_tag    = '0;
    m_fill   = 0;
    m_drain  = 0;
    m_words.delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    return !m_fill && !m_drain && m_valid && (pc[31:4] == m_tag);
  endfunction

  function automatic logic [31:0] m_addr();
    if (m_drain) return m_drain_addr;
    return {m_fill_tag, 4'b0000} + 32'(m_words.size() * 4);
  endfunction

  task automatic check_cycle(input logic [31:0] pc);
    bit eh;
    eh = m_hit(pc);
    check("stall", {31'b0, stall_out}, {31'b0, !eh});
    check("instr", instr_out, eh ? m_line[pc[3:2]] : NOP);
    check("req", {31'b0, mem_req}, {31'b0, (m_fill || m_drain)});
    if (m_fill || m_drain) check("addr", mem_addr, m_addr());
`ifdef FETCH_RESPONDER_PERF_EN
    check("hit_count", hit_count_out, m_hits);
    check("miss_count", miss_count_out, m_misses);
`endif
  endtask

  task automatic model_step(input logic [31:0] pc, input logic sp, input logic ack);
    if (m_fill) begin
      if (ack) begin
        m_words.push_back(memfn(m_addr()));
        if (m_words.size() == 4) begin
          for (int i = 0; i < 4; i++) m_line[i] = m_words[i];
          m_valid = 1'b1;
          m_tag   = m_fill_tag;
          m_fill  = 0;
        end else if (sp) begin
          m_fill = 0;
        end
      end else if (sp) begin
        m_drain_addr = m_addr();
        m_fill       = 0;
        m_drain      = 1;
      end
    end else if (m_drain) begin
      if (ack) m_drain = 0;
    end else if (!m_hit(pc)) begin
      m_fill     = 1;
      m_fill_tag = pc[31:4];
      m_words.delete();
      m_valid    = 1'b0;
      m_misses++;
    end else if (!sp) begin
      m_hits++;
    end
  endtask

  // One clock cycle: called just after a falling edge, drives inputs, checks
  // outputs against the model, then advances to the next falling edge.
  task automatic cycle(input logic [31:0] pc, input logic sp, input logic ack);
    pc_in     = pc;
    set_pc_in = sp;
    mem_ack   = ack;
    mem_rdata = memfn(mem_addr);
    #1;
    check_cycle(pc);
    model_step(pc, sp, ack);
    @(negedge clock);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        sp;
    logic        ack;
    logic        exp_stall;
    logic [31:0] exp_instr;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rpc;
    logic        rsp;
    logic        rack;

    vecs[0]  = '{32'h0100_0000, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'h0};
    vecs[1]  = '{32'h0100_0000, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0000};
    vecs[2]  = '{32'h0100_0000, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0004};
    vecs[3]  = '{32'h0100_0000, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0008};
    vecs[4]  = '{32'h0100_0000, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_000C};
    vecs[5]  = '{32'h0100_0000, 1'b0, 1'b0, 1'b0, memfn(32'h0100_0000), 1'b0, 32'h0};
    vecs[6]  = '{32'h0100_0004, 1'b0, 1'b0, 1'b0, memfn(32'h0100_0004), 1'b0, 32'h0};
    vecs[7]  = '{32'h0100_0008, 1'b0, 1'b0, 1'b0, memfn(32'h0100_0008), 1'b0, 32'h0};
    vecs[8]  = '{32'h0100_000C, 1'b0, 1'b0, 1'b0, memfn(32'h0100_000C), 1'b0, 32'h0};
    vecs[9]  = '{32'h0100_0010, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'h0};
    vecs[10] = '{32'h0100_0010, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0010};
    vecs[11] = '{32'h0100_0010, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0014};
    vecs[12] = '{32'h0100_0010, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_0018};
    vecs[13] = '{32'h0100_0010, 1'b0, 1'b1, 1'b1, NOP, 1'b1, 32'h0100_001C};
    vecs[14] = '{32'h0100_0014, 1'b0, 1'b0, 1'b0, memfn(32'h0100_0014), 1'b0, 32'h0};

    model_reset();

    // Reset state.
    pc_in = 32'h0100_0000;
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", {31'b0, stall_out}, 32'd1);
    check("rst_instr", instr_out, NOP);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Cold start, sequential hits, line crossing.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].pc, vecs[i].sp, vecs[i].ack);
      // Values of the cycle just applied were sampled inside cycle(); the
      // table is compared here against the same pre-edge snapshot by
      // re-checking the model-independent fields recorded below.
    end

    // Same table again, applied without the model, comparing only against
    // the table's constant expectations after a fresh reset.
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pc_in     = vecs[i].pc;
      set_pc_in = vecs[i].sp;
      mem_ack   = vecs[i].ack;
      mem_rdata = memfn(mem_addr);
      #1;
      check($sformatf("tbl%0d_stall", i), {31'b0, stall_out}, {31'b0, vecs[i].exp_stall});
      check($sformatf("tbl%0d_instr", i), instr_out, vecs[i].exp_instr);
      check($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].exp_addr);
      model_step(vecs[i].pc, vecs[i].sp, vecs[i].ack);
      @(negedge clock);
    end

    // Three wait states per beat: stall released 16 cycles after first request.
    cycle(32'h0300_0000, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        pc_in = 32'h0300_0000;
        #0;
        check("ws_addr", mem_addr, 32'h0300_0000 + 32'(b * 4));
        check("ws_stall", {31'b0, stall_out}, 32'd1);
        cycle(32'h0300_0000, 1'b0, (w == 3));
      end
    end
    #1;
    check("ws_release", {31'b0, stall_out}, 32'd0);
    check("ws_word0", instr_out, memfn(32'h0300_0000));
    cycle(32'h0300_0008, 1'b0, 1'b0);

    // Redirect with no ack during beat 1: drain, then refill at the new PC.
    cycle(32'h0100_0000, 1'b0, 1'b0);
    cycle(32'h0100_0000, 1'b0, 1'b1);
    cycle(32'h0200_0000, 1'b1, 1'b0);
    pc_in = 32'h0200_0000;
    #1;
    check("drain_addr0", mem_addr, 32'h0100_0004);
    cycle(32'h0200_0000, 1'b1, 1'b0);
    #1;
    check("drain_addr1", mem_addr, 32'h0100_0004);
    check("drain_stall", {31'b0, stall_out}, 32'd1);
    cycle(32'h0200_0000, 1'b0, 1'b1);
    cycle(32'h0200_0000, 1'b0, 1'b0);
    #1;
    check("refill_addr", mem_addr, 32'h0200_0000);
    check("refill_req", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(32'h0200_0000, 1'b0, 1'b1);
    #1;
    check("refill_hit", instr_out, memfn(32'h0200_0000));
    cycle(32'h0200_0004, 1'b0, 1'b0);
    pc_in = 32'h0100_0000;
    #1;
    check("old_line_miss", {31'b0, stall_out}, 32'd1);

    // Reset mid-fill at beat 2.
    cycle(32'h0100_0000, 1'b0, 1'b0);
    cycle(32'h0100_0000, 1'b0, 1'b1);
    cycle(32'h0100_0000, 1'b0, 1'b1);
    mem_ack = 1'b0;
    #1;
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    check("pre_rst_addr", mem_addr, 32'h0100_0008);
    reset = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'b0, stall_out}, 32'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    pc_in = 32'h0200_0000;
    #1;
    check("post_rst_old_miss", {31'b0, stall_out}, 32'd1);
    cycle(32'h0100_0000, 1'b0, 1'b0);
    #1;
    check("post_rst_refill", mem_addr, 32'h0100_0000);

    // Randomized traffic with spurious acks, redirects and variable latency.
    rpc = 32'h0100_0000;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      rsp = 1'b0;
      if (r >= 5 && r < 8) begin
        rpc = rpc + 32'd4;
      end else if (r >= 8) begin
        rpc = (32'h0100_0000 << $urandom_range(0, 1)) + 32'($urandom_range(0, 11) * 4);
        rsp = 1'b1;
      end
      if (mem_req) rack = ($urandom_range(0, 2) == 0);
      else         rack = ($urandom_range(0, 7) == 0);
      cycle(rpc, rsp, rack);
      if (rpc[15:0] > 16'h0040) rpc = 32'h0100_0000;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
- Instruction-side responder for the fetch stage.
- Takes fetch's PC and redirect, and returns the instruction word combinationally in the same cycle.
- Asserts a stall when the word is not available.
- Backs a single-line instruction buffer with a word-wide request/acknowledge memory port. Sits between fetch and the instruction memory/bus.

Parameters:
- LINE_WORDS_LOG2, 2, log2 of words per line (4 words, 16 bytes).
- NOP_INSTR, 32'h00000013, word driven on instr_out whenever no valid word is available.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pc_in  in  32  fetch PC (arch_reg); pc_in[1:0] ignored.
- set_pc_in  in  1  fetch redirect; high in the same cycle fetch loads a new PC.
- instr_out  out  32  instruction for pc_in (arch_reg).
- stall_out  out  1  high: instr_out is not valid; fetch must hold PC.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned read address.
- mem_ack  in  1  request accepted and mem_rdata valid this cycle.
- mem_rdata  in  32  read data.

Behaviour:
- State:
  - line buffer of 2^LINE_WORDS_LOG2 words
  - line_tag = pc[31:LINE_WORDS_LOG2+2]
  - line_valid
  - beat counter (LINE_WORDS_LOG2 bits)
  - FSM {IDLE, FILL, DRAIN}
- Reset (reset low, async):
  - state=IDLE, line_valid=0, beat=0, line_tag=0, mem_req=0, mem_addr=0.
  - While reset is low: stall_out=1, instr_out=NOP_INSTR.
- hit = state==IDLE && line_valid && pc_in tag == line_tag.
- Outputs, combinational from state and pc_in:
  - On hit: instr_out = line[pc_in[LINE_WORDS_LOG2+1:2]], stall_out=0.
  - Otherwise: instr_out=NOP_INSTR, stall_out=1.
- IDLE:
  - On miss (tag mismatch or line_valid=0): next cycle goes to FILL.
  - Latches line_tag from pc_in, sets beat=0, clears line_valid.
  - set_pc_in in IDLE needs no action; the next PC is looked up on the next cycle.
- FILL:
  - mem_req=1, mem_addr={line_tag, beat, 2'b00}.
  - Fill order is word 0 upward; no critical-word-first.
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack: write mem_rdata into line[beat] and increment beat.
  - On mem_ack at the last beat: line_valid=1, go to IDLE; the hit is visible the next cycle.
  - Zero-wait memory (ack same cycle as req): miss in cycle 0, beats in cycles 1..4, stall_out low in cycle 5.
- Redirect during FILL:
  - set_pc_in with mem_ack on the last beat: fill completes normally; the new PC is looked up in IDLE.
  - set_pc_in with mem_ack on a non-last beat: data is discarded, line_valid stays 0, go to IDLE.
  - set_pc_in without mem_ack: go to DRAIN.
- DRAIN:
  - Holds mem_req=1 and mem_addr stable; an outstanding request is never withdrawn.
  - On mem_ack: discard the data, go to IDLE with line_valid=0.
  - set_pc_in in DRAIN is ignored.
  - stall_out=1 throughout.
- Line crossing: sequential PC 0x...0C to 0x...10 changes the tag, which is a miss and triggers a fresh fill.
- Reset during FILL or DRAIN: immediate abort; mem_req drops asynchronously.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro FETCH_RESPONDER_PERF_EN.
- When defined, adds two outputs:
  - hit_count_out  out  32: increments on each cycle with hit && !set_pc_in.
  - miss_count_out  out  32: increments on each IDLE-to-FILL transition.
- Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, the ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Cold start, reset released, pc_in=0x01000000, memory acks same cycle:
  - mem_addr sequence 0x01000000, 0x01000004, 0x01000008, 0x0100000C in cycles 1-4.
  - stall_out=1 in cycles 0-4, then instr_out=word0 with stall_out=0 in cycle 5.
- After the fill, pc_in steps 0x01000004, 0x01000008, 0x0100000C: hits with stall_out=0 and correct words; mem_req stays 0.
- Memory with 3 wait states per beat: mem_addr is held stable while mem_ack=0; stall_out is released 16 cycles after the first mem_req.
- set_pc_in to 0x02000000 during beat 1 with no ack:
  - DRAIN holds mem_addr=0x01000004 until ack.
  - Next, IDLE misses and a fill starts at 0x02000000.
  - The old line never hits.
- pc_in moves 0x0100000C to 0x01000010: miss, stall_out=1, new fill starting at 0x01000010.
- reset asserted mid-FILL at beat 2:
  - mem_req=0 immediately.
  - After release, pc_in=0x01000000 misses again; the line was invalidated.
